// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out path:
// 640x480@60 timing, 320x240 RGB444 source image geometry,
// RGB444 field positions and the colour-bar lookup.
package vga_pkg;

    // 640x480@60 horizontal timing (pixels)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // 640x480@60 vertical timing (lines)
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Source image held in BRAM, shown with 2x pixel and line replication
    localparam int VGA_IMG_W      = 320;
    localparam int VGA_IMG_H      = 240;
    localparam int VGA_IMG_PIXELS = VGA_IMG_W * VGA_IMG_H;

    localparam int VGA_ADDR_W = 17;
    localparam int VGA_PIX_W  = 12;

    // RGB444 field slices
    localparam int RGB_R_HI = 11;
    localparam int RGB_R_LO = 8;
    localparam int RGB_G_HI = 7;
    localparam int RGB_G_LO = 4;
    localparam int RGB_B_HI = 3;
    localparam int RGB_B_LO = 0;

    // Control bits that travel alongside the BRAM read
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic first;
    } vga_ctl_t;

    // Blank, syncs inactive: what the pipeline holds out of reset
    localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

    // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        logic [2:0]  on;
        logic [11:0] rgb;
        case (idx)
            3'd0:    on = 3'b111;
            3'd1:    on = 3'b110;
            3'd2:    on = 3'b011;
            3'd3:    on = 3'b010;
            3'd4:    on = 3'b101;
            3'd5:    on = 3'b100;
            3'd6:    on = 3'b001;
            default: on = 3'b000;
        endcase
        rgb = '0;
        rgb[RGB_R_HI:RGB_R_LO] = {4{on[2]}};
        rgb[RGB_G_HI:RGB_G_LO] = {4{on[1]}};
        rgb[RGB_B_HI:RGB_B_LO] = {4{on[0]}};
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for VGA timing. hcnt/vcnt advance only on pix_ce;
// active, hs_n, vs_n and the wrap strobes are decoded combinationally
// from the current counter values.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HCW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VCW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_ce,
    output logic [HCW-1:0] hcnt,
    output logic [VCW-1:0] vcnt,
    output logic           active,
    output logic           hs_n,
    output logic           vs_n,
    output logic           line_end,
    output logic           frame_end
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = V_ACTIVE + V_FP + V_SYNC;

    // Raster position: hcnt wraps each line, vcnt steps on hcnt wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_ce) begin
            if (line_end) begin
                hcnt <= '0;
                vcnt <= frame_end ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Decode wrap points, visible region and sync windows
    always_comb begin
        line_end  = (hcnt == HCW'(H_TOTAL - 1));
        frame_end = line_end && (vcnt == VCW'(V_TOTAL - 1));
        active    = (hcnt < HCW'(H_ACTIVE)) && (vcnt < VCW'(V_ACTIVE));
        hs_n      = !((hcnt >= HCW'(HS_START)) && (hcnt < HCW'(HS_END)));
        vs_n      = !((vcnt >= VCW'(VS_START)) && (vcnt < VCW'(VS_END)));
    end

endmodule

// File: rtl/vga_image_reader.sv
// VGA scan-out from a 320x240 RGB444 image BRAM to a 640x480@60 display.
// Each source pixel is shown 2x2: the column is hcnt/2 and the line base
// steps by IMG_W after every odd visible line, so no multiplier is needed.
// Control bits (active/syncs/first-pixel) are delayed by 1+BRAM_LAT pix_ce
// ticks so they line up with the BRAM read data at the output registers.
// Optional build macro VGA_TEST_PATTERN_EN adds a pattern_sel input that
// replaces the image with eight vertical colour bars.
module vga_image_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int IMG_W    = VGA_IMG_W,
    parameter int ADDR_W   = VGA_ADDR_W,
    parameter int PIX_W    = VGA_PIX_W,
    parameter int BRAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [PIX_W-1:0]  bram_data,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [PIX_W-1:0]  vga_rgb,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    logic [HCW-1:0]    hcnt;
    logic [VCW-1:0]    vcnt;
    logic              active;
    logic              hs_n;
    logic              vs_n;
    logic              line_end;
    logic              frame_end;

    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] col;
    vga_ctl_t          ctl_now;
    vga_ctl_t          ctl_pipe [0:BRAM_LAT];
    vga_ctl_t          ctl_out;
    logic [PIX_W-1:0]  pix_src;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HCW      (HCW),
        .VCW      (VCW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .active    (active),
        .hs_n      (hs_n),
        .vs_n      (vs_n),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Horizontal replication: two screen pixels per source pixel
    assign col = ADDR_W'(hcnt >> 1);

    // Line base tracks the start of the current source row; odd visible
    // lines are the second copy of a row, so the base advances after them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
            bram_addr <= '0;
        end else if (pix_ce) begin
            bram_addr <= active ? (line_base + col) : '0;
            if (frame_end) begin
                line_base <= '0;
            end else if (line_end && vcnt[0] && (vcnt < VCW'(V_ACTIVE))) begin
                line_base <= line_base + ADDR_W'(IMG_W);
            end
        end
    end

    // Control bits sampled alongside the address register
    always_comb begin
        ctl_now        = CTL_IDLE;
        ctl_now.active = active;
        ctl_now.hs_n   = hs_n;
        ctl_now.vs_n   = vs_n;
        ctl_now.first  = active && (hcnt == '0) && (vcnt == '0);
    end

    // Stage 0 matches the address register, the rest match BRAM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= BRAM_LAT; i++) begin
                ctl_pipe[i] <= CTL_IDLE;
            end
        end else if (pix_ce) begin
            ctl_pipe[0] <= ctl_now;
            for (int i = 1; i <= BRAM_LAT; i++) begin
                ctl_pipe[i] <= ctl_pipe[i-1];
            end
        end
    end

    assign ctl_out = ctl_pipe[BRAM_LAT];

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;
    logic [2:0] bar_pipe [0:BRAM_LAT];

    // Bar number from hcnt by threshold compare against multiples of BAR_W
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (32'(hcnt) >= 32'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    // Bar number rides the same delay as the control bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= BRAM_LAT; i++) begin
                bar_pipe[i] <= '0;
            end
        end else if (pix_ce) begin
            bar_pipe[0] <= bar_idx;
            for (int i = 1; i <= BRAM_LAT; i++) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
        end
    end

    assign pix_src = pattern_sel ? PIX_W'(bar_rgb(bar_pipe[BRAM_LAT])) : bram_data;
`else
    assign pix_src = bram_data;
`endif

    // Output registers; frame_start is a single-clk strobe, the rest hold
    // between pix_ce ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && ctl_out.first;
            if (pix_ce) begin
                vga_hs  <= ctl_out.hs_n;
                vga_vs  <= ctl_out.vs_n;
                vga_de  <= ctl_out.active;
                vga_rgb <= ctl_out.active ? pix_src : '0;
            end
        end
    end

endmodule

// File: doc/vga_image_reader.md
Name: vga_image_reader

Overview:
- Scan-out stage feeding the 320x240 RGB444 image BRAM (17-bit address, 12-bit data, registered read).
- Generates 640x480@60 VGA timing and the BRAM read address, with 2x pixel/line replication.
- Delays sync/blank to match BRAM read latency and drives the VGA pins with the returned pixel data.
- Sits between the image_bram instance and the board VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_W, 320, source image width
- IMG_H, 240, source image height
- ADDR_W, 17, BRAM address width
- PIX_W, 12, pixel width (RGB444: [11:8]=R, [7:4]=G, [3:0]=B)
- BRAM_LAT, 1, BRAM read latency in pix_ce ticks (1..3)

Ports:
- clk, in, 1, system clock (50 MHz)
- rst, in, 1, asynchronous active-high reset
- pix_ce, in, 1, pixel-rate enable; all timing advances only when high (1-in-2 gives 25 MHz)
- bram_addr, out, ADDR_W, read address to image BRAM
- bram_data, in, PIX_W, BRAM read data
- vga_hs, out, 1, horizontal sync, active low
- vga_vs, out, 1, vertical sync, active low
- vga_de, out, 1, display-enable, aligned with vga_rgb
- vga_rgb, out, PIX_W, pixel to DAC; 0 when vga_de low
- frame_start, out, 1, one-clk pulse on the pix_ce of the first output pixel (h=0, v=0)

Behaviour:
- Reset (async, rst=1): hcnt=vcnt=0, line_base=0, bram_addr=0, vga_hs=vga_vs=1, vga_de=0, vga_rgb=0, frame_start=0, delay pipeline cleared to blank/inactive.
- Counters, on pix_ce only:
  - hcnt 0..H_TOTAL-1 (799), wraps to 0; vcnt increments on hcnt wrap, 0..V_TOTAL-1 (524), wraps to 0.
  - No state changes on clocks where pix_ce=0; all outputs hold.
- Raw timing:
  - active = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
  - hs_n low for hcnt in [656,752); vs_n low for vcnt in [490,492).
- Address generation, multiplier-free:
  - bram_addr = line_base + hcnt[9:1] while active, else 0; registered, updated on pix_ce, held between ticks.
  - At hcnt wrap: if vcnt is odd and vcnt<V_ACTIVE, line_base += IMG_W. At frame wrap, line_base = 0.
  - Maximum address is 76799; never exceeded.
- Alignment:
  - active, hs_n and vs_n pass through a shift pipeline of depth 1+BRAM_LAT (address register plus BRAM latency), advancing on pix_ce.
  - Outputs are registered: vga_de = delayed active; vga_rgb = bram_data if delayed active else 0; vga_hs/vga_vs = delayed syncs.
  - Address-to-pixel latency is 1+BRAM_LAT pix_ce ticks; sync edges carry the same delay, so relative timing is exact.
- frame_start asserts for exactly one clk, coincident with vga_de rising for pixel (0,0).
- Reset mid-frame: immediate return to reset values; the next frame starts at h=0, v=0 after release. The first frame_start follows after 1+BRAM_LAT ticks.
- pix_ce held high continuously is legal (pixel clock = clk).

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: adds input port pattern_sel (1 bit). When high, vga_rgb shows 8 vertical colour bars, each 80 px wide: white, yellow, cyan, green, magenta, red, blue, black (components 0xF/0x0). Bars use the same delay pipeline, so timing is identical; bram_addr is still generated.
- Undefined: no port, no bar logic; vga_rgb is always BRAM data.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480 timing constants and derived H_TOTAL=800, V_TOTAL=525;
  - IMG_W, IMG_H, IMG_PIXELS=76800;
  - RGB444 field slices.
- One natural sub-module, vga_timing_gen: counters, raw hs_n/vs_n/active and hcnt/vcnt outputs. The address generator, delay pipeline and output mux stay in the top module.

Test Plan:
- Reset, pix_ce toggling 1-in-2 -> vga_hs/vga_vs=1, vga_de=0, bram_addr=0. hsync low for exactly 96 ticks, period 800 ticks; vsync low for 2 lines, period 525 lines.
- Active-area address trace -> (h=0,v=0)=0; (h=1,v=0)=0; (h=2,v=0)=1; (h=639,v=1)=319; (h=0,v=2)=320; (h=639,v=479)=76799; blanking=0.
- BRAM model returning data=addr[11:0] with BRAM_LAT=1 and 2 -> vga_rgb equals the addr issued 1+BRAM_LAT ticks earlier. vga_de rises exactly then; vga_rgb=0 in blanking.
- frame_start over 3 frames -> exactly one single-clk pulse per 420000 pix_ce ticks, coincident with the first vga_de rising.
- rst asserted at v=200, h=300 for 3 clks -> outputs at reset values immediately. After release, bram_addr sequence restarts at 0; the first frame_start follows after 1+BRAM_LAT ticks.
- VGA_TEST_PATTERN_EN defined, pattern_sel=1 -> h=0..79 gives 0xFFF, h=80..159 gives 0xFF0, ..., h=560..639 gives 0x000. Same de/sync alignment as BRAM mode.
